// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX operand forwarding.
// Optional macro FORWARDING_EN enables MEM/WB forwarding; without it dependent instructions stall instead.
module id_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_alu_src,
  input  logic [2:0]      id_alu_control,
  input  logic            id_reg_write,
  input  logic            id_mem_write,
  input  logic            id_mem_read,
  input  logic            ex_flush,
  input  logic [4:0]      mem_rd,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [4:0]      wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic            stall_id,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_src_a,
  output logic [XLEN-1:0] ex_src_b,
  output logic [2:0]      ex_alu_control,
  output logic [XLEN-1:0] ex_write_data,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_write,
  output logic            ex_mem_read,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm
);

  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [XLEN-1:0] ex_rd1;
  logic [XLEN-1:0] ex_rd2;
  logic            ex_alu_src;
  logic            bubble_c;

  // x0 is never a real dependency
  function automatic logic hit(input logic [4:0] rs, input logic [4:0] rd);
    return (rs != 5'd0) && (rs == rd);
  endfunction

  // Hazard detection against the instruction sitting in decode
  always_comb begin
    stall_id = 1'b0;
    if (id_valid && ex_valid && ex_mem_read && (hit(id_rs1, ex_rd) || hit(id_rs2, ex_rd)))
      stall_id = 1'b1;
`ifndef FORWARDING_EN
    if (id_valid && ex_valid && ex_reg_write && (hit(id_rs1, ex_rd) || hit(id_rs2, ex_rd)))
      stall_id = 1'b1;
    if (id_valid && mem_reg_write && (hit(id_rs1, mem_rd) || hit(id_rs2, mem_rd)))
      stall_id = 1'b1;
`endif
  end

  assign bubble_c = stall_id | ex_flush;

  // EX register: data always captured, control bits squashed on a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid       <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_rd          <= 5'd0;
      ex_rs1         <= 5'd0;
      ex_rs2         <= 5'd0;
      ex_alu_control <= 3'd0;
      ex_alu_src     <= 1'b0;
      ex_pc          <= '0;
      ex_imm         <= '0;
      ex_rd1         <= '0;
      ex_rd2         <= '0;
    end else begin
      ex_valid       <= id_valid & ~bubble_c;
      ex_reg_write   <= id_reg_write & ~bubble_c;
      ex_mem_write   <= id_mem_write & ~bubble_c;
      ex_mem_read    <= id_mem_read & ~bubble_c;
      ex_rd          <= id_rd;
      ex_rs1         <= id_rs1;
      ex_rs2         <= id_rs2;
      ex_alu_control <= id_alu_control;
      ex_alu_src     <= id_alu_src;
      ex_pc          <= id_pc;
      ex_imm         <= id_imm;
      ex_rd1         <= id_rd1;
      ex_rd2         <= id_rd2;
    end
  end

`ifdef FORWARDING_EN
  // MEM result is younger than WB, so it wins when both match
  always_comb begin
    ex_src_a = ex_rd1;
    if (mem_reg_write && hit(ex_rs1, mem_rd))
      ex_src_a = mem_alu_result;
    else if (wb_reg_write && hit(ex_rs1, wb_rd))
      ex_src_a = wb_result;

    ex_write_data = ex_rd2;
    if (mem_reg_write && hit(ex_rs2, mem_rd))
      ex_write_data = mem_alu_result;
    else if (wb_reg_write && hit(ex_rs2, wb_rd))
      ex_write_data = wb_result;
  end
`else
  always_comb begin
    ex_src_a      = ex_rd1;
    ex_write_data = ex_rd2;
  end

  logic unused_fwd;
  assign unused_fwd = ^{mem_alu_result, wb_rd, wb_reg_write, wb_result, ex_rs1, ex_rs2};
`endif

  assign ex_src_b = ex_alu_src ? ex_imm : ex_write_data;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage; expectations follow FORWARDING_EN when defined.
module tb_id_ex_stage;

`ifdef FORWARDING_EN
  localparam int F = 1;
`else
  localparam int F = 0;
`endif
  localparam int NF = 1 - F;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rd1, id_rd2, id_imm, id_pc;
  logic        id_alu_src;
  logic [2:0]  id_alu_control;
  logic        id_reg_write, id_mem_write, id_mem_read;
  logic        ex_flush;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [31:0] mem_alu_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_result;
  logic        stall_id, ex_valid;
  logic [31:0] ex_src_a, ex_src_b, ex_write_data, ex_pc, ex_imm;
  logic [2:0]  ex_alu_control;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_write, ex_mem_read;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc(id_pc),
    .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_mem_read(id_mem_read),
    .ex_flush(ex_flush),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_alu_result(mem_alu_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_src_a(ex_src_a), .ex_src_b(ex_src_b), .ex_alu_control(ex_alu_control),
    .ex_write_data(ex_write_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
    .ex_pc(ex_pc), .ex_imm(ex_imm)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall, valid, rw, mw, mr, chk;
    logic [4:0]  rd;
    logic [2:0]  ctl;
    logic [31:0] a, b, wd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0h expected=%0h @%0t", nm, fld, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp(e.name, "stall_id", 32'(stall_id), 32'(e.stall));
        cmp(e.name, "ex_valid", 32'(ex_valid), 32'(e.valid));
        cmp(e.name, "ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
        cmp(e.name, "ex_mem_write", 32'(ex_mem_write), 32'(e.mw));
        cmp(e.name, "ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
        if (e.chk) begin
          cmp(e.name, "ex_rd", 32'(ex_rd), 32'(e.rd));
          cmp(e.name, "ex_alu_control", 32'(ex_alu_control), 32'(e.ctl));
          cmp(e.name, "ex_src_a", ex_src_a, e.a);
          cmp(e.name, "ex_src_b", ex_src_b, e.b);
          cmp(e.name, "ex_write_data", ex_write_data, e.wd);
        end
      end
    end
  end

  task automatic push_exp(input string nm, input int stall, input int valid, input int rw,
                          input int mw, input int mr, input int chk, input int rd, input int ctl,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] wd);
    exp_t e;
    e.name = nm; e.stall = 1'(stall); e.valid = 1'(valid); e.rw = 1'(rw);
    e.mw = 1'(mw); e.mr = 1'(mr); e.chk = 1'(chk); e.rd = 5'(rd); e.ctl = 3'(ctl);
    e.a = a; e.b = b; e.wd = wd;
    sb.push_back(e);
  endtask

  task automatic push_idle(input string nm);
    push_exp(nm, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic set_id(input int v, input int rs1, input int rs2, input int rd,
                        input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                        input logic [31:0] pc, input int src, input int ctl,
                        input int rw, input int mw, input int mr);
    id_valid = 1'(v); id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_pc = pc;
    id_alu_src = 1'(src); id_alu_control = 3'(ctl);
    id_reg_write = 1'(rw); id_mem_write = 1'(mw); id_mem_read = 1'(mr);
  endtask

  task automatic idle_id();
    set_id(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_fwd(input int mrd, input int mrw, input logic [31:0] mres,
                         input int wrd, input int wrw, input logic [31:0] wres);
    mem_rd = 5'(mrd); mem_reg_write = 1'(mrw); mem_alu_result = mres;
    wb_rd = 5'(wrd); wb_reg_write = 1'(wrw); wb_result = wres;
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  // Stimulus: each step drives one cycle and pushes what that cycle must show
  initial begin
    rst = 1'b1; ex_flush = 1'b0;
    idle_id();
    set_fwd(0, 0, 32'h0, 0, 0, 32'h0);
    next();
    push_exp("rst_cycle1", 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0);
    next();
    rst = 1'b0;

    set_id(1, 1, 2, 9, 32'h10, 32'h20, 32'h4, 32'h100, 0, 0, 1, 0, 0);
    push_exp("after_rst", 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0);
    next();
    set_id(1, 5, 0, 6, 32'h55, 32'h0, 32'h8, 32'h104, 1, 1, 1, 0, 0);
    set_fwd(5, 1, 32'h1234, 0, 0, 32'h0);
    push_exp("p_in_ex", NF, 1, 1, 0, 0, 1, 9, 0, 32'h10, 32'h20, 32'h20);
    next();
    idle_id();
    push_exp("fwd_mem_a", 0, F, F, 0, 0, F, 6, 1, 32'h1234, 32'h8, 32'h0);
    next();
    set_id(1, 3, 7, 10, 32'h33, 32'h77, 32'h0, 32'h108, 0, 3, 1, 0, 0);
    set_fwd(0, 0, 32'h0, 0, 0, 32'h0);
    push_idle("idle1");
    next();
    idle_id();
    set_fwd(7, 1, 32'hAAAA, 7, 1, 32'hBBBB);
    push_exp("mem_over_wb", 0, 1, 1, 0, 0, 1, 10, 3, 32'h33,
             F ? 32'hAAAA : 32'h77, F ? 32'hAAAA : 32'h77);
    next();
    set_id(1, 12, 0, 0, 32'h1212, 32'h0, 32'h40, 32'h10c, 1, 2, 0, 0, 0);
    set_fwd(0, 0, 32'h0, 0, 0, 32'h0);
    push_idle("idle2");
    next();
    idle_id();
    set_fwd(12, 0, 32'hDEAD, 12, 1, 32'hBBBB);
    push_exp("wb_fwd", 0, 1, 0, 0, 0, 1, 0, 2, F ? 32'hBBBB : 32'h1212, 32'h40, 32'h0);
    next();

    // load into x3 followed by a dependent instruction
    set_id(1, 1, 2, 3, 32'h11, 32'h22, 32'h10, 32'h110, 1, 0, 1, 0, 1);
    set_fwd(0, 0, 32'h0, 0, 0, 32'h0);
    push_idle("idle3");
    next();
    set_id(1, 3, 4, 11, 32'h3, 32'h4, 32'h0, 32'h114, 0, 4, 1, 0, 0);
    push_exp("load_use_stall", 1, 1, 1, 0, 1, 1, 3, 0, 32'h11, 32'h10, 32'h22);
    next();
    set_fwd(3, 1, 32'h999, 0, 0, 32'h0);
    push_exp("load_bubble", NF, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    next();
    if (F != 0) idle_id();
    set_fwd(0, 0, 32'h0, 3, 1, 32'h5A5A);
    push_exp("dep_capture", 0, F, F, 0, 0, F, 11, 4, 32'h5A5A, 32'h4, 32'h4);
    next();
    idle_id();
    set_fwd(0, 0, 32'h0, 0, 0, 32'h0);
    push_exp("dep_late", 0, NF, NF, 0, 0, NF, 11, 4, 32'h3, 32'h4, 32'h4);
    next();

    // x0 never forwards; flush squashes a valid store
    set_id(1, 0, 0, 13, 32'h0, 32'h0, 32'h0, 32'h118, 0, 0, 1, 0, 0);
    push_idle("idle4");
    next();
    set_id(1, 1, 2, 14, 32'h1, 32'h2, 32'h0, 32'h11c, 0, 0, 1, 1, 0);
    ex_flush = 1'b1;
    set_fwd(0, 1, 32'hFFFF, 0, 1, 32'hEEEE);
    push_exp("x0_no_fwd", 0, 1, 1, 0, 0, 1, 13, 0, 32'h0, 32'h0, 32'h0);
    next();
    ex_flush = 1'b0;
    idle_id();
    set_fwd(0, 0, 32'h0, 0, 0, 32'h0);
    push_idle("flush_bubble");
    next();

    // flush and load-use stall in the same cycle
    set_id(1, 1, 2, 20, 32'h1, 32'h2, 32'h8, 32'h120, 1, 0, 1, 0, 1);
    push_idle("idle5");
    next();
    set_id(1, 20, 0, 21, 32'h5, 32'h0, 32'h0, 32'h124, 0, 0, 1, 0, 0);
    ex_flush = 1'b1;
    push_exp("flush_stall", 1, 1, 1, 0, 1, 1, 20, 0, 32'h1, 32'h8, 32'h2);
    next();
    ex_flush = 1'b0;
    idle_id();
    push_idle("single_bubble");
    next();

    // reset while a load-use hazard is pending
    set_id(1, 1, 2, 22, 32'h1, 32'h2, 32'h8, 32'h128, 1, 0, 1, 0, 1);
    push_idle("idle6");
    next();
    set_id(1, 22, 0, 23, 32'h7, 32'h0, 32'h0, 32'h12c, 0, 0, 1, 0, 0);
    rst = 1'b1;
    push_exp("pre_rst_stall", 1, 1, 1, 0, 1, 1, 22, 0, 32'h1, 32'h8, 32'h2);
    next();
    rst = 1'b0;
    push_exp("rst_mid_stall", 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0);
    next();
    idle_id();
    push_exp("post_rst_capture", 0, 1, 1, 0, 0, 1, 23, 0, 32'h7, 32'h0, 32'h0);
    next();

    // ALU write to x4 followed by a reader of x4
    set_id(1, 1, 2, 4, 32'h1, 32'h2, 32'h0, 32'h130, 0, 0, 1, 0, 0);
    push_idle("idle7");
    next();
    set_id(1, 0, 4, 5, 32'h0, 32'h44, 32'h0, 32'h134, 0, 3, 1, 0, 0);
    push_exp("alu_dep_stall1", NF, 1, 1, 0, 0, 1, 4, 0, 32'h1, 32'h2, 32'h2);
    next();
    if (F != 0) idle_id();
    set_fwd(4, 1, 32'h4444, 0, 0, 32'h0);
    push_exp("alu_dep_stall2", NF, F, F, 0, 0, F, 5, 3, 32'h0, 32'h4444, 32'h4444);
    next();
    if (F != 0) idle_id();
    set_fwd(0, 0, 32'h0, 4, 1, 32'h4444);
    push_idle("alu_dep_release");
    next();
    idle_id();
    set_fwd(0, 0, 32'h0, 0, 0, 32'h0);
    push_exp("alu_dep_capture", 0, NF, NF, 0, 0, NF, 5, 3, 32'h0, 32'h44, 32'h44);
    next();

    for (int i = 0; i < 10 && sb.size() > 0; i++) next();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
